// File: rtl/prog_ctr_fetch.sv
// Program counter and fetch sequencer: launches a program from a selectable
// start address, steps/branches each cycle, halts on the done instruction.
module prog_ctr_fetch #(
  parameter int unsigned     PC_W        = 10,
  parameter logic [PC_W-1:0] PROG0_START = '0,
  parameter logic [PC_W-1:0] PROG1_START = '0,
  parameter logic [PC_W-1:0] PROG2_START = '0,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             Taken,
  input  logic [PC_W-1:0]  Target,
  input  logic             Halt,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [PC_W-1:0]  start_pc;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    start_pc = PROG2_START;
    case (ProgSel)
      2'd0:    start_pc = PROG0_START;
      2'd1:    start_pc = PROG1_START;
      default: start_pc = PROG2_START;
    endcase
  end

  // Executed-instruction count sticks at all-ones rather than wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = start_pc;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Stall freezes everything, masking halt and branch for the cycle.
        if (!Stall) begin
          cnt_d = cnt_inc;
          if (Halt) begin
            state_d = HALTED;
            done_d  = 1'b1;
          end else if (BranchEn && Taken) begin
            pc_d = Target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign ProgCtr   = pc_q;
  assign Running   = (state_q == RUN);
  assign Done      = done_q;
  assign InstCount = cnt_q;

endmodule

// File: tb/tb_prog_ctr_fetch.sv
// Directed vector table plus a wrap/saturation sequence for prog_ctr_fetch.
module tb_prog_ctr_fetch;
  localparam int PC_W  = 10;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Reset, Start, Stall, BranchEn, Taken, Halt;
  logic [1:0]       ProgSel;
  logic [PC_W-1:0]  Target;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running, Done;
  logic [CNT_W-1:0] InstCount;

  prog_ctr_fetch #(
    .PC_W(PC_W), .PROG0_START(10'd1022), .PROG1_START(10'd40),
    .PROG2_START(10'd200), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
    .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .Halt(Halt),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .InstCount(InstCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic rst, start; logic [1:0] sel; logic stall, br, tk; int tgt; logic halt;
    int pc; logic run, done; int cnt;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic start, input int sel, input logic stall,
                     input logic br, input logic tk, input int tgt, input logic halt,
                     input int pc, input logic run, input logic done, input int cnt);
    vec_t v;
    v.rst = rst; v.start = start; v.sel = 2'(sel); v.stall = stall; v.br = br; v.tk = tk;
    v.tgt = tgt; v.halt = halt; v.pc = pc; v.run = run; v.done = done; v.cnt = cnt;
    vt.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    Reset = v.rst; Start = v.start; ProgSel = v.sel; Stall = v.stall;
    BranchEn = v.br; Taken = v.tk; Target = PC_W'(v.tgt); Halt = v.halt;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int idx, input int pc,
                            input logic run, input logic done, input int cnt);
    chk({tag, ".ProgCtr"},   idx, int'(ProgCtr),   pc);
    chk({tag, ".Running"},   idx, int'(Running),   int'(run));
    chk({tag, ".Done"},      idx, int'(Done),      int'(done));
    chk({tag, ".InstCount"}, idx, int'(InstCount), cnt);
  endtask

  initial begin
    //   rst st sel stl br tk tgt hlt |  pc run dn cnt
    add(1, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0, 0);  // reset two cycles
    add(1, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 1, 1, 1, 7, 1,   0, 0, 0, 0);  // idle ignores stall/branch/halt
    add(0, 1, 1, 0, 0, 0,  0, 0,   40, 1, 0, 0);  // launch prog1
    add(0, 0, 0, 0, 0, 0,  0, 0,   41, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0,   42, 1, 0, 2);
    add(0, 1, 2, 0, 0, 0,  0, 0,   43, 1, 0, 3);  // start mid-run ignored
    add(0, 0, 0, 0, 0, 0,  0, 0,   44, 1, 0, 4);
    add(0, 0, 0, 0, 0, 0,  0, 0,   45, 1, 0, 5);
    add(0, 0, 0, 0, 1, 1, 12, 0,   12, 1, 0, 6);  // taken to 12
    add(0, 0, 0, 0, 1, 1, 15, 0,   15, 1, 0, 7);  // taken to 15
    add(0, 0, 0, 0, 1, 0, 19, 0,   16, 1, 0, 8);  // not taken
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 1, 1, 1, 5, 1,  16, 1, 0, 8);  // stall beats halt and branch
    add(0, 0, 0, 0, 1, 1,  5, 1,   16, 0, 1, 9);  // halt beats branch
    add(0, 0, 0, 0, 0, 0,  0, 0,   16, 0, 0, 9);  // done was a single pulse
    add(0, 0, 0, 0, 0, 0,  0, 0,   16, 0, 0, 9);
    add(0, 1, 2, 0, 0, 0,  0, 0,  200, 1, 0, 0);  // relaunch prog2
    add(0, 0, 0, 0, 0, 0,  0, 0,  201, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1, 30, 0,   30, 1, 0, 2);
    add(1, 1, 1, 0, 0, 0,  0, 1,    0, 0, 0, 0);  // reset mid-run overrides halt
    add(0, 0, 0, 0, 0, 0,  0, 0,    0, 0, 0, 0);  // no done pulse
    add(0, 1, 0, 0, 0, 0,  0, 0, 1022, 1, 0, 0);  // launch prog0, wrap
    add(0, 0, 0, 0, 0, 0,  0, 0, 1023, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0,    0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0,  0, 0,    1, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0,  0, 1,    1, 0, 1, 4);  // halt
    add(0, 0, 0, 0, 0, 0,  0, 0,    1, 0, 0, 4);
    add(0, 1, 3, 0, 0, 0,  0, 0,  200, 1, 0, 0);  // sel 3 uses prog2 start
    add(0, 0, 0, 0, 0, 0,  0, 1,  200, 0, 1, 1);  // halt
    add(0, 1, 0, 0, 0, 0,  0, 0, 1022, 1, 0, 0);  // start during done cycle

    Reset = 1'b1; Start = 1'b0; ProgSel = '0; Stall = 1'b0;
    BranchEn = 1'b0; Taken = 1'b0; Target = '0; Halt = 1'b0;
    @(negedge Clk);
    foreach (vt[i]) begin
      apply(vt[i]);
      check_outs("vec", i, vt[i].pc, vt[i].run, vt[i].done, vt[i].cnt);
    end

    // Running from 1022 (launched above): wrap through 0 and saturate count at 15.
    begin
      vec_t v;
      int pc_exp, cnt_exp;
      v = vt[0];
      v.rst = 0; v.start = 0; v.stall = 0; v.br = 0; v.tk = 0; v.halt = 0; v.tgt = 0;
      pc_exp = 1022; cnt_exp = 0;
      for (int i = 0; i < 20; i++) begin
        apply(v);
        pc_exp  = (pc_exp + 1) % 1024;
        cnt_exp = (cnt_exp < 15) ? cnt_exp + 1 : 15;
        check_outs("sat", i, pc_exp, 1'b1, 1'b0, cnt_exp);
      end
      v.halt = 1;
      apply(v);
      check_outs("sat_halt", 0, pc_exp, 1'b0, 1'b1, 15);
      v.halt = 0;
      apply(v);
      check_outs("sat_halt", 1, pc_exp, 1'b0, 1'b0, 15);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_ctr_fetch.md
# prog_ctr_fetch

Program-counter and fetch-sequencing stage sitting directly downstream of the branch-target lookup table. Holds the 10-bit instruction-memory address, advances it each cycle, loads the absolute 10-bit branch target on a taken branch, and sequences program start/halt through a Start/Done handshake. Also counts executed instructions for the test harness.

## Interface
- PC_W, 10, width of ProgCtr and Target (instruction-memory address width)
- PROG0_START, 0, start address loaded when ProgSel = 0
- PROG1_START, 0, start address loaded when ProgSel = 1
- PROG2_START, 0, start address loaded when ProgSel = 2 (ProgSel = 3 also uses PROG2_START)
- CNT_W, 16, width of InstCount
- Clk  input  1  single clock, all state on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  launch request, sampled only in IDLE or HALTED
- ProgSel  input  2  selects start address, sampled with Start
- Stall  input  1  freezes PC and counter for the cycle
- BranchEn  input  1  current instruction is a branch
- Taken  input  1  branch condition true (from ALU flag)
- Target  input  PC_W  absolute jump address from the target lookup table
- Halt  input  1  current instruction is the halt/done instruction
- ProgCtr  output  PC_W  current instruction-memory address
- Running  output  1  high while in RUN
- Done  output  1  one-cycle pulse when a program halts
- InstCount  output  CNT_W  instructions executed since last launch

## Operation
- States: IDLE, RUN, HALTED (registered, 2-bit encoding).
- Reset (takes effect at the edge where Reset = 1, overrides every other input, including mid-RUN): state IDLE, ProgCtr = 0, Running = 0, Done = 0, InstCount = 0.
- IDLE / HALTED, Start = 1: next state RUN; ProgCtr loads start address per ProgSel; InstCount cleared to 0. Stall, BranchEn, Halt ignored in these states.
- IDLE / HALTED, Start = 0: hold all registers; Done = 0.
- RUN, per cycle, priority highest first:
  - Stall = 1: ProgCtr, InstCount, state all hold; Halt/branch ignored this cycle.
  - Halt = 1: next state HALTED; ProgCtr holds (points at the halt instruction); InstCount increments (halt counts as executed); Done = 1 next cycle.
  - BranchEn = 1 and Taken = 1: ProgCtr = Target; InstCount increments.
  - Otherwise (including BranchEn = 1, Taken = 0): ProgCtr = ProgCtr + 1, modulo 2^PC_W (1023 wraps to 0); InstCount increments.
- Start while in RUN: ignored.
- InstCount saturates at all-ones; no wrap.
- Running = 1 exactly when state is RUN.
- Done is registered and high for exactly one cycle, the first cycle in HALTED; if Start is asserted in that same cycle, Done still pulses and the relaunch proceeds.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Launch latency: Start sampled at edge N → Running = 1 and ProgCtr = start address visible after edge N.
- Branch latency: BranchEn, Taken, Target sampled at edge N → ProgCtr = Target after edge N (one cycle, no delay slot).
- Halt latency: Halt sampled at edge N → Running = 0, Done = 1 after edge N; Done = 0 after edge N+1.
- Target is treated as full PC_W-bit absolute address; no sign-extension or offset arithmetic.

## Test plan
- Reset then idle: assert Reset 2 cycles, release, hold Start = 0 for 5 cycles → ProgCtr = 0, Running = 0, Done = 0, InstCount = 0 throughout.
- Launch and sequential run: PROG1_START = 40, Start with ProgSel = 1, run 5 cycles no branch → ProgCtr 40, 41, 42, 43, 44, 45; InstCount = 5; Start pulse mid-run has no effect.
- Taken vs not-taken branch: at ProgCtr = 12, BranchEn = 1, Taken = 1, Target = 15 → next ProgCtr = 15; at 15, BranchEn = 1, Taken = 0, Target = 19 → next ProgCtr = 16.
- Stall and priority: Stall = 1 with Halt = 1 and taken branch for 3 cycles → ProgCtr and InstCount frozen, stays RUN; drop Stall with Halt = 1 → HALTED, Done high exactly 1 cycle, ProgCtr unchanged.
- Wrap and saturation: launch at PROG0_START = 1022 → ProgCtr 1022, 1023, 0, 1; with CNT_W = 4, run 20 cycles → InstCount sticks at 15.
- Reset mid-run and relaunch: Reset during RUN at ProgCtr = 30 → next cycle IDLE, ProgCtr = 0, Done never pulses; Start with ProgSel = 2 after a halt → ProgCtr = PROG2_START, InstCount = 0.
